// File: rtl/irs_multi_buffer_manager.sv
// IRS multi-buffer manager: per-buffer lock counters, post-lock sampling window
// and round-robin selection of the next free write buffer (pauses when none is free).
module irs_multi_buffer_manager #(
  parameter int ADDR_BITS        = 9,
  parameter int BUF_BITS         = 2,
  parameter int CNT_BITS         = ADDR_BITS - BUF_BITS + 1,
  parameter int POST_LOCK_CYCLES = 100
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_BITS-1:0]  lock_address_i,
  input  logic                  lock_i,
  input  logic                  lock_strobe_i,
  output logic                  lock_ack_o,
  input  logic [ADDR_BITS-1:0]  free_address_i,
  input  logic                  free_strobe_i,
  output logic                  free_ack_o,
  output logic [BUF_BITS-1:0]   write_buffer_o,
  output logic                  buffer_switch_o,
  output logic                  irs_pause_o,
  output logic [BUF_BITS:0]     free_buffers_o,
  output logic                  lock_err_o,
  output logic [7:0]            debug_o
);

  localparam int NBUF = 2 ** BUF_BITS;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_TWO = CNT_BITS'(2);
  localparam logic [7:0] WAIT_END = 8'(POST_LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_WRITE    = 2'd0,
    ST_POSTLOCK = 2'd1,
    ST_PAUSED   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [7:0]           wait_cnt, wait_next;
  logic [BUF_BITS-1:0]  wb_next;
  logic                 switch_next;
  logic                 pause_next;

  logic [CNT_BITS-1:0]  cnt      [NBUF];
  logic [CNT_BITS-1:0]  cnt_next [NBUF];
  logic [NBUF-1:0]      step_err;
  logic [BUF_BITS:0]    free_next;

  logic [BUF_BITS-1:0]  lock_buf, free_buf;
  logic                 lock_hit;
  logic                 found;
  logic [BUF_BITS-1:0]  pick;
  logic [BUF_BITS-1:0]  idx;

  logic [1:0]           dbg_buf;
  logic [3:0]           dbg_cnt;

  // Saturating counter step: returns {blocked, new_count}. A lock and a
  // release in the same cycle cancel; a double release floors at zero.
  function automatic logic [CNT_BITS:0] sat_step(input logic [CNT_BITS-1:0] c,
                                                 input logic inc,
                                                 input logic [1:0] dec);
    logic [CNT_BITS-1:0] r;
    logic                err;
    r   = c;
    err = 1'b0;
    if (inc && dec == 2'd0) begin
      if (&c) err = 1'b1;
      else    r   = c + CNT_ONE;
    end else if ((inc && dec == 2'd2) || (!inc && dec == 2'd1)) begin
      if (c == '0) err = 1'b1;
      else         r   = c - CNT_ONE;
    end else if (!inc && dec == 2'd2) begin
      if (c >= CNT_TWO) begin
        r = c - CNT_TWO;
      end else begin
        r   = '0;
        err = 1'b1;
      end
    end
    return {err, r};
  endfunction

  assign lock_buf = lock_address_i[ADDR_BITS-1 -: BUF_BITS];
  assign free_buf = free_address_i[ADDR_BITS-1 -: BUF_BITS];
  assign lock_hit = lock_strobe_i & lock_i & (lock_buf == write_buffer_o);

  always_comb begin
    logic       inc;
    logic [1:0] dec;
    free_next = '0;
    for (int i = 0; i < NBUF; i++) begin
      inc = lock_strobe_i & lock_i & (lock_buf == BUF_BITS'(i));
      dec = {1'b0, lock_strobe_i & ~lock_i & (lock_buf == BUF_BITS'(i))}
          + {1'b0, free_strobe_i & (free_buf == BUF_BITS'(i))};
      {step_err[i], cnt_next[i]} = sat_step(cnt[i], inc, dec);
      if (cnt_next[i] == '0) free_next = free_next + 1'b1;
    end
  end

  // Round-robin search from the buffer after the current one; the current
  // buffer is visited last. Iterating backwards lets the nearest hit win.
  always_comb begin
    found = 1'b0;
    pick  = write_buffer_o;
    idx   = write_buffer_o;
    for (int k = NBUF; k >= 1; k--) begin
      idx = write_buffer_o + BUF_BITS'(k);
      if (cnt[idx] == '0) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    wb_next     = write_buffer_o;
    switch_next = 1'b0;
    pause_next  = 1'b0;
    case (state)
      ST_WRITE: begin
        if (lock_hit) begin
          state_next = ST_POSTLOCK;
          wait_next  = '0;
        end
      end
      ST_POSTLOCK: begin
        if (wait_cnt == WAIT_END) begin
          if (cnt[write_buffer_o] == '0) begin
            state_next = ST_WRITE;
          end else if (found) begin
            wb_next     = pick;
            switch_next = 1'b1;
            state_next  = ST_WRITE;
          end else begin
            state_next = ST_PAUSED;
            pause_next = 1'b1;
          end
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      ST_PAUSED: begin
        pause_next = 1'b1;
        if (found) begin
          wb_next     = pick;
          switch_next = (pick != write_buffer_o);
          pause_next  = 1'b0;
          state_next  = ST_WRITE;
        end
      end
      default: begin
        state_next = ST_WRITE;
      end
    endcase
  end

  // Registered stage: counters, FSM, acks and status outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NBUF; i++) cnt[i] <= '0;
      state           <= ST_WRITE;
      wait_cnt        <= '0;
      write_buffer_o  <= '0;
      buffer_switch_o <= 1'b0;
      irs_pause_o     <= 1'b0;
      free_buffers_o  <= '0;
      lock_err_o      <= 1'b0;
      lock_ack_o      <= 1'b0;
      free_ack_o      <= 1'b0;
    end else begin
      for (int i = 0; i < NBUF; i++) cnt[i] <= cnt_next[i];
      state           <= state_next;
      wait_cnt        <= wait_next;
      write_buffer_o  <= wb_next;
      buffer_switch_o <= switch_next;
      irs_pause_o     <= pause_next;
      free_buffers_o  <= free_next;
      lock_err_o      <= lock_err_o | (|step_err);
      lock_ack_o      <= lock_strobe_i;
      free_ack_o      <= free_strobe_i;
    end
  end

  always_comb begin
    dbg_buf = 2'(write_buffer_o);
    dbg_cnt = 4'(cnt[write_buffer_o]);
  end

  assign debug_o = {state, dbg_buf, dbg_cnt};

endmodule

// File: tb/tb_irs_multi_buffer_manager.sv
// Scoreboard bench for irs_multi_buffer_manager: expected acks and buffer
// switches are queued at stimulus time and matched when the DUT emits them.
module tb_irs_multi_buffer_manager;

  localparam int AB   = 9;
  localparam int BB   = 2;
  localparam int P    = 100;
  localparam int NBUF = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [AB-1:0] lock_address_i;
  logic          lock_i;
  logic          lock_strobe_i;
  logic          lock_ack_o;
  logic [AB-1:0] free_address_i;
  logic          free_strobe_i;
  logic          free_ack_o;
  logic [BB-1:0] write_buffer_o;
  logic          buffer_switch_o;
  logic          irs_pause_o;
  logic [BB:0]   free_buffers_o;
  logic          lock_err_o;
  logic [7:0]    debug_o;

  irs_multi_buffer_manager #(
    .ADDR_BITS(AB), .BUF_BITS(BB), .POST_LOCK_CYCLES(P)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .lock_address_i(lock_address_i), .lock_i(lock_i),
    .lock_strobe_i(lock_strobe_i), .lock_ack_o(lock_ack_o),
    .free_address_i(free_address_i), .free_strobe_i(free_strobe_i),
    .free_ack_o(free_ack_o), .write_buffer_o(write_buffer_o),
    .buffer_switch_o(buffer_switch_o), .irs_pause_o(irs_pause_o),
    .free_buffers_o(free_buffers_o), .lock_err_o(lock_err_o),
    .debug_o(debug_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int buf_id;
  } sw_t;

  sw_t sw_q[$];
  int  lack_q[$];
  int  fack_q[$];
  sw_t sw_e;

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (lock_ack_o) begin
        if (lack_q.size() == 0) check("lock_ack_unexpected", lock_ack_o, 0);
        else                    check("lock_ack_cycle", cyc, lack_q.pop_front());
      end
      if (free_ack_o) begin
        if (fack_q.size() == 0) check("free_ack_unexpected", free_ack_o, 0);
        else                    check("free_ack_cycle", cyc, fack_q.pop_front());
      end
      if (buffer_switch_o) begin
        if (sw_q.size() == 0) begin
          check("switch_unexpected", write_buffer_o, NBUF);
        end else begin
          sw_e = sw_q.pop_front();
          check("switch_cycle", cyc, sw_e.cyc);
          check("switch_buffer", write_buffer_o, sw_e.buf_id);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      lock_strobe_i = 1'b0;
      free_strobe_i = 1'b0;
    end
  endtask

  task automatic lock_req(input logic [AB-1:0] a, input logic l);
    @(posedge clk_i); #1;
    lock_address_i = a;
    lock_i         = l;
    lock_strobe_i  = 1'b1;
    free_strobe_i  = 1'b0;
    lack_q.push_back(cyc + 1);
  endtask

  task automatic free_req(input logic [AB-1:0] a);
    @(posedge clk_i); #1;
    free_address_i = a;
    free_strobe_i  = 1'b1;
    lock_strobe_i  = 1'b0;
    fack_q.push_back(cyc + 1);
  endtask

  task automatic lock_and_free(input logic [AB-1:0] la, input logic [AB-1:0] fa);
    @(posedge clk_i); #1;
    lock_address_i = la;
    lock_i         = 1'b1;
    lock_strobe_i  = 1'b1;
    free_address_i = fa;
    free_strobe_i  = 1'b1;
    lack_q.push_back(cyc + 1);
    fack_q.push_back(cyc + 1);
  endtask

  initial begin
    rst_n_i        = 1'b0;
    lock_address_i = '0;
    lock_i         = 1'b0;
    lock_strobe_i  = 1'b0;
    free_address_i = '0;
    free_strobe_i  = 1'b0;

    repeat (3) @(negedge clk_i);
    check("rst_write_buffer", write_buffer_o, 0);
    check("rst_pause", irs_pause_o, 0);
    check("rst_free_buffers", free_buffers_o, 0);
    check("rst_lock_err", lock_err_o, 0);
    check("rst_debug", debug_o, 0);
    check("rst_switch", buffer_switch_o, 0);
    rst_n_i = 1'b1;
    idle(2);
    check("idle_free_buffers", free_buffers_o, 4);

    // Lock then unlock in buffer 0 inside the window: no switch
    lock_req(9'h010, 1'b1);
    idle(10);
    check("win_state_postlock", debug_o[7:6], 1);
    lock_req(9'h010, 1'b0);
    idle(P + 5);
    check("win_state_write", debug_o[7:6], 0);
    check("win_write_buffer", write_buffer_o, 0);
    check("win_free_buffers", free_buffers_o, 4);

    // Same-cycle lock and free to one buffer cancel out
    lock_req(9'h030, 1'b1);
    lock_and_free(9'h031, 9'h032);
    idle(2);
    check("net0_count", debug_o[3:0], 1);
    check("net0_err", lock_err_o, 0);
    lock_req(9'h030, 1'b0);
    idle(P + 5);
    check("net0_state_write", debug_o[7:6], 0);
    check("net0_write_buffer", write_buffer_o, 0);

    // Free of an already empty buffer is blocked and flagged
    free_req(9'h1F0);
    idle(3);
    check("underflow_err", lock_err_o, 1);
    check("underflow_free_buffers", free_buffers_o, 4);

    // Lock in the active buffer: switch to buffer 1 after the window
    lock_req(9'h005, 1'b1);
    sw_q.push_back('{cyc + P + 2, 1});
    idle(20);
    check("a_pause_in_window", irs_pause_o, 0);
    check("a_state_postlock", debug_o[7:6], 1);
    idle(P);
    check("a_write_buffer", write_buffer_o, 1);
    check("a_pause_after", irs_pause_o, 0);
    check("a_free_buffers", free_buffers_o, 3);
    free_req(9'h005);
    idle(3);
    check("a_free_back", free_buffers_o, 4);

    // Lock every buffer: the writer has nowhere to go and pauses
    lock_req(9'h080, 1'b1);
    lock_req(9'h100, 1'b1);
    lock_req(9'h180, 1'b1);
    lock_req(9'h005, 1'b1);
    idle(P + 5);
    check("b_pause", irs_pause_o, 1);
    check("b_free_buffers", free_buffers_o, 0);
    check("b_state_paused", debug_o[7:6], 2);
    check("b_write_buffer", write_buffer_o, 1);

    // Releasing buffer 2 resumes writing there
    free_req(9'h100);
    sw_q.push_back('{cyc + 2, 2});
    idle(4);
    check("c_write_buffer", write_buffer_o, 2);
    check("c_pause", irs_pause_o, 0);
    check("c_state_write", debug_o[7:6], 0);
    check("c_free_buffers", free_buffers_o, 1);

    // Re-enter PAUSED, then reset asynchronously with an ack in flight
    lock_req(9'h101, 1'b1);
    idle(P + 5);
    check("d_pause", irs_pause_o, 1);
    @(posedge clk_i); #1;
    lock_address_i = 9'h1F1;
    lock_i         = 1'b1;
    lock_strobe_i  = 1'b1;
    @(posedge clk_i); #1;
    lock_strobe_i  = 1'b0;
    check("d_ack_before_reset", lock_ack_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("d_rst_pause", irs_pause_o, 0);
    check("d_rst_write_buffer", write_buffer_o, 0);
    check("d_rst_lock_ack", lock_ack_o, 0);
    check("d_rst_free_ack", free_ack_o, 0);
    check("d_rst_debug", debug_o, 0);
    check("d_rst_err", lock_err_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(3);
    check("d_post_free_buffers", free_buffers_o, 4);
    check("d_post_pause", irs_pause_o, 0);

    check("pending_switches", sw_q.size(), 0);
    check("pending_lock_acks", lack_q.size(), 0);
    check("pending_free_acks", fack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
